// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two issue front ends (master) and the shared
// ALU arbiter (slave).
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [1:0]  req0_ctrl;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [1:0]  req1_ctrl;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [31:0] rsp0_res;
  logic [3:0]  rsp0_flags;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp1_res;
  logic [3:0]  rsp1_flags;

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_ctrl, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_res, rsp0_flags,
    input  req1_ready, rsp1_valid, rsp1_res, rsp1_flags
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_ctrl, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_res, rsp0_flags,
    output req1_ready, rsp1_valid, rsp1_res, rsp1_flags
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a single 32-bit add/sub/and/or ALU.
// One operation in flight: IDLE accepts, EXEC registers the ALU result, RESP waits for pickup.
module alu_arbiter #(
  parameter int unsigned PRIO_INIT = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             port_q, port_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [31:0]      res0_q, res0_d, res1_q, res1_d;
  logic [3:0]       flags0_q, flags0_d, flags1_q, flags1_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic        gnt0, gnt1, idle, rsp_ready_sel;
  logic [31:0] b_eff, alu_res;
  logic [32:0] sum;
  logic        alu_c, alu_v;
  logic [3:0]  alu_flags;

  // Shared ALU, fed only from the operand registers.
  always_comb begin
    b_eff   = (ctrl_q == 2'b01) ? ~b_q : b_q;
    sum     = {1'b0, a_q} + {1'b0, b_eff} + {32'b0, (ctrl_q == 2'b01)};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (ctrl_q)
      2'b00, 2'b01: begin
        alu_res = sum[31:0];
        alu_c   = sum[32];
        alu_v   = (a_q[31] == b_eff[31]) && (sum[31] != a_q[31]);
      end
      2'b10:   alu_res = a_q & b_q;
      default: alu_res = a_q | b_q;
    endcase
    alu_flags = {alu_res[31], (alu_res == 32'd0), alu_c, alu_v};
  end

  // Port 1 wins when alone or when it holds priority.
  assign gnt1 = bus.req1_valid & (~bus.req0_valid | prio_q);
  assign gnt0 = bus.req0_valid & ~gnt1;
  assign idle = (state_q == StIdle) && !rst;

  assign bus.req0_ready = idle & gnt0;
  assign bus.req1_ready = idle & gnt1;
  assign rsp_ready_sel  = port_q ? bus.rsp1_ready : bus.rsp0_ready;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    port_d      = port_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    rsp_valid_d = rsp_valid_q;
    res0_d      = res0_q;
    res1_d      = res1_q;
    flags0_d    = flags0_q;
    flags1_d    = flags1_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    unique case (state_q)
      StIdle: begin
        if (gnt0 || gnt1) begin
          port_d  = gnt1;
          a_d     = gnt1 ? bus.req1_a : bus.req0_a;
          b_d     = gnt1 ? bus.req1_b : bus.req0_b;
          ctrl_d  = gnt1 ? bus.req1_ctrl : bus.req0_ctrl;
          state_d = StExec;
        end
      end
      StExec: begin
        if (port_q) begin
          res1_d   = alu_res;
          flags1_d = alu_flags;
        end else begin
          res0_d   = alu_res;
          flags0_d = alu_flags;
        end
        rsp_valid_d[port_q] = 1'b1;
        prio_d              = ~port_q;
        state_d             = StResp;
      end
      StResp: begin
        if (rsp_valid_q[port_q] && rsp_ready_sel) begin
          rsp_valid_d[port_q] = 1'b0;
          if (port_q) begin
            if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
          end else begin
            if (cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      prio_q      <= 1'(PRIO_INIT);
      port_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      rsp_valid_q <= '0;
      res0_q      <= '0;
      res1_q      <= '0;
      flags0_q    <= '0;
      flags1_q    <= '0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      port_q      <= port_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      rsp_valid_q <= rsp_valid_d;
      res0_q      <= res0_d;
      res1_q      <= res1_d;
      flags0_q    <= flags0_d;
      flags1_q    <= flags1_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign bus.rsp0_valid = rsp_valid_q[0];
  assign bus.rsp1_valid = rsp_valid_q[1];
  assign bus.rsp0_res   = res0_q;
  assign bus.rsp1_res   = res1_q;
  assign bus.rsp0_flags = flags0_q;
  assign bus.rsp1_flags = flags1_q;
  assign busy           = (state_q != StIdle);
  assign cnt0           = cnt0_q;
  assign cnt1           = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table plus directed sequences, with a request/response
// scoreboard fed from an independent arithmetic model.
module tb_alu_arbiter;
  localparam int unsigned CntW   = 2;
  localparam int unsigned CntMax = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            busy;
  logic [CntW-1:0] cnt0, cnt1;

  alu_arbiter_if bus ();

  alu_arbiter #(
    .PRIO_INIT(0),
    .CNT_W    (CntW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy),
    .cnt0(cnt0),
    .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic [31:0] res;
    logic [3:0]  flags;
  } exp_t;

  typedef struct {
    logic        port;
    logic [1:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;
  } vec_t;

  exp_t sb_q[$];
  logic grant_log[$];
  int   n_checks = 0;
  int   n_errs = 0;
  int   exp_cnt0 = 0;
  int   exp_cnt1 = 0;
  bit   hs0, hs1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed/unsigned 64-bit reference arithmetic.
  function automatic exp_t model(input logic p, input logic [1:0] c, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t   e;
    longint ua, ub, sa, sb, ur, sr;
    logic   cf, vf;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cf = 1'b0;
    vf = 1'b0;
    e.port = p;
    case (c)
      2'b00: begin
        ur = ua + ub;
        sr = sa + sb;
        e.res = ur[31:0];
        cf = (ur >= 64'h1_0000_0000);
        vf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      2'b01: begin
        ur = ua - ub;
        sr = sa - sb;
        e.res = ur[31:0];
        cf = (ua >= ub);
        vf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      2'b10:   e.res = a & b;
      default: e.res = a | b;
    endcase
    e.flags = {e.res[31], (e.res == 32'd0), cf, vf};
    return e;
  endfunction

  task automatic check_rsp(input logic p, input logic [31:0] res, input logic [3:0] flags);
    exp_t e;
    chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("rsp_port", 64'(p), 64'(e.port));
      chk("rsp_res", 64'(res), 64'(e.res));
      chk("rsp_flags", 64'(flags), 64'(e.flags));
    end
    if (p) begin
      chk("cnt1_before", 64'(cnt1), 64'(exp_cnt1));
      if (exp_cnt1 < CntMax) exp_cnt1++;
    end else begin
      chk("cnt0_before", 64'(cnt0), 64'(exp_cnt0));
      if (exp_cnt0 < CntMax) exp_cnt0++;
    end
  endtask

  // Observes handshakes just before the rising edge that commits them.
  task automatic monitor();
    hs0 = 1'b0;
    hs1 = 1'b0;
    if (rst) begin
      sb_q.delete();
      exp_cnt0 = 0;
      exp_cnt1 = 0;
    end else begin
      chk("single_grant", 64'(bus.req0_ready & bus.req1_ready), 64'd0);
      chk("rsp_exclusive", 64'(bus.rsp0_valid & bus.rsp1_valid), 64'd0);
      if (bus.req0_valid && bus.req0_ready) begin
        sb_q.push_back(model(1'b0, bus.req0_ctrl, bus.req0_a, bus.req0_b));
        grant_log.push_back(1'b0);
        hs0 = 1'b1;
      end
      if (bus.req1_valid && bus.req1_ready) begin
        sb_q.push_back(model(1'b1, bus.req1_ctrl, bus.req1_a, bus.req1_b));
        grant_log.push_back(1'b1);
        hs1 = 1'b1;
      end
      if (bus.rsp0_valid && bus.rsp0_ready) check_rsp(1'b0, bus.rsp0_res, bus.rsp0_flags);
      if (bus.rsp1_valid && bus.rsp1_ready) check_rsp(1'b1, bus.rsp1_res, bus.rsp1_flags);
    end
  endtask

  // Called at a falling edge after inputs are set; returns at the next falling edge.
  task automatic step();
    #1;
    monitor();
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic issue(input logic p, input logic [1:0] c, input logic [31:0] a,
                       input logic [31:0] b);
    bit done = 1'b0;
    if (p) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_ctrl = c; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_ctrl = c; bus.req0_valid = 1'b1;
    end
    for (int i = 0; i < 50 && !done; i++) begin
      step();
      done = p ? hs1 : hs0;
    end
    if (!done) chk("req_timeout", 64'd0, 64'd1);
    if (p) bus.req1_valid = 1'b0;
    else   bus.req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(input logic p, output logic [31:0] res, output logic [3:0] flags);
    bit done = 1'b0;
    res   = '0;
    flags = '0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (p ? bus.rsp1_valid : bus.rsp0_valid) begin
        res   = p ? bus.rsp1_res : bus.rsp0_res;
        flags = p ? bus.rsp1_flags : bus.rsp0_flags;
        done  = 1'b1;
      end
      step();
    end
    if (!done) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[8];
    logic [31:0] r, hold_r;
    logic [3:0]  f, hold_f;
    int          seq[5];

    vecs[0] = '{1'b0, 2'b01, 32'd5,          32'd3,          32'd2,          4'b0010};
    vecs[1] = '{1'b1, 2'b00, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  4'b1001};
    vecs[2] = '{1'b1, 2'b00, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000,  4'b0110};
    vecs[3] = '{1'b0, 2'b10, 32'hF0F0_F0F0,  32'h0F0F_0F0F,  32'h0000_0000,  4'b0100};
    vecs[4] = '{1'b1, 2'b11, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  4'b0000};
    vecs[5] = '{1'b0, 2'b01, 32'd3,          32'd5,          32'hFFFF_FFFE,  4'b1000};
    vecs[6] = '{1'b1, 2'b01, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  4'b0011};
    vecs[7] = '{1'b0, 2'b00, 32'h8000_0000,  32'h8000_0000,  32'h0000_0000,  4'b0111};
    seq = '{1, 2, 3, 3, 3};

    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctrl = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctrl = '0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    do_reset();

    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp0_valid", 64'(bus.rsp0_valid), 64'd0);
    chk("rst_rsp1_valid", 64'(bus.rsp1_valid), 64'd0);
    chk("rst_rsp0_res", 64'(bus.rsp0_res), 64'd0);
    chk("rst_rsp1_flags", 64'(bus.rsp1_flags), 64'd0);
    chk("rst_cnt0", 64'(cnt0), 64'd0);
    chk("rst_cnt1", 64'(cnt1), 64'd0);

    // Port 0 alone: 5 - 3, two-cycle latency to rsp_valid.
    bus.req0_a = 32'd5; bus.req0_b = 32'd3; bus.req0_ctrl = 2'b01; bus.req0_valid = 1'b1;
    #1;
    chk("lat_req0_ready", 64'(bus.req0_ready), 64'd1);
    chk("lat_req1_ready", 64'(bus.req1_ready), 64'd0);
    step();
    bus.req0_valid = 1'b0;
    chk("lat_exec_busy", 64'(busy), 64'd1);
    chk("lat_exec_valid", 64'(bus.rsp0_valid), 64'd0);
    step();
    chk("lat_resp_valid", 64'(bus.rsp0_valid), 64'd1);
    chk("lat_res", 64'(bus.rsp0_res), 64'd2);
    chk("lat_flags", 64'(bus.rsp0_flags), 64'b0010);
    step();
    chk("lat_cnt0", 64'(cnt0), 64'd1);
    chk("lat_idle", 64'(busy), 64'd0);

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].port, vecs[i].ctrl, vecs[i].a, vecs[i].b);
      wait_rsp(vecs[i].port, r, f);
      chk($sformatf("vec%0d_res", i), 64'(r), 64'(vecs[i].res));
      chk($sformatf("vec%0d_flags", i), 64'(f), 64'(vecs[i].flags));
    end

    // Both ports requesting continuously: grants must alternate from port 0.
    do_reset();
    grant_log.delete();
    bus.req0_a = 32'd1;    bus.req0_b = 32'd1;    bus.req0_ctrl = 2'b00;
    bus.req1_a = 32'hF0;   bus.req1_b = 32'h0F;   bus.req1_ctrl = 2'b11;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 24; i++) step();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    for (int i = 0; i < 10 && busy; i++) step();
    chk("rr_count", 64'(grant_log.size() >= 6), 64'd1);
    foreach (grant_log[i]) chk($sformatf("rr_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));

    // Response backpressure on port 0.
    bus.rsp0_ready = 1'b0;
    issue(1'b0, 2'b00, 32'd10, 32'd20);
    for (int i = 0; i < 10 && !bus.rsp0_valid; i++) step();
    hold_r = bus.rsp0_res;
    hold_f = bus.rsp0_flags;
    chk("bp_res", 64'(hold_r), 64'd30);
    bus.req1_a = 32'd7; bus.req1_b = 32'd7; bus.req1_ctrl = 2'b10; bus.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", 64'(bus.rsp0_valid), 64'd1);
      chk("bp_res_hold", 64'(bus.rsp0_res), 64'(hold_r));
      chk("bp_flags_hold", 64'(bus.rsp0_flags), 64'(hold_f));
      chk("bp_req1_ready", 64'(bus.req1_ready), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
      step();
    end
    bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b1;
    step();
    chk("bp_release_idle", 64'(busy), 64'd0);
    chk("bp_release_valid", 64'(bus.rsp0_valid), 64'd0);
    chk("bp_res_retained", 64'(bus.rsp0_res), 64'd30);

    // Reset while in EXEC discards the operation.
    issue(1'b0, 2'b00, 32'd1, 32'd2);
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_busy_rst", 64'(busy), 64'd0);
    chk("mid_rsp0_valid", 64'(bus.rsp0_valid), 64'd0);
    chk("mid_rsp0_res", 64'(bus.rsp0_res), 64'd0);
    chk("mid_rsp0_flags", 64'(bus.rsp0_flags), 64'd0);
    chk("mid_cnt0", 64'(cnt0), 64'd0);
    chk("mid_cnt1", 64'(cnt1), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_rsp", 64'(bus.rsp0_valid | bus.rsp1_valid), 64'd0);
    end

    // Counter saturation with a 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, 2'b11, 32'(i), 32'h100);
      wait_rsp(1'b0, r, f);
      chk($sformatf("sat_cnt0_%0d", i), 64'(cnt0), 64'(seq[i]));
    end
    chk("sat_cnt1", 64'(cnt1), 64'd0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
